// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: region decode, per-slave ack handshake, registered CPU response.
// Optional hung-slave timeout enabled by defining DBUS_TIMEOUT_EN.
module dbus_interconnect #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_LSB  = 28,
    parameter int TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_ce,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic [N_SLAVES-1:0]          slv_ce,
    output logic                         slv_we,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic [DATA_W-1:0]            slv_wdata,
    input  logic [N_SLAVES*DATA_W-1:0]   slv_rdata,
    input  logic [N_SLAVES-1:0]          slv_ack
);

    if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
        $error("dbus_interconnect: N_SLAVES must be in 1..16");
    end
    if (SEL_LSB < 0 || SEL_LSB + 4 > ADDR_W) begin : g_bad_sel_lsb
        $error("dbus_interconnect: region index field must lie inside the address");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("dbus_interconnect: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]          w_idx;
    logic [N_SLAVES-1:0] w_dec_ce;
    logic                w_mapped;
    logic                w_sel_ack;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic                w_timeout;

    logic [N_SLAVES-1:0] w_slv_ce_nxt;
    logic                w_slv_we_nxt;
    logic [ADDR_W-1:0]   w_slv_addr_nxt;
    logic [DATA_W-1:0]   w_slv_wdata_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_ready_nxt;
    logic                w_err_nxt;

    // Region decode; an index beyond the last slave yields an all-zero select.
    assign w_idx = cpu_addr[SEL_LSB+3:SEL_LSB];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_dec_ce = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            w_dec_ce[i] = (w_idx == 4'(i));
        end
    end

    assign w_mapped = |w_dec_ce;

    // The held one-hot select doubles as the response mux control, so stray acks are masked.
    assign w_sel_ack = |(slv_ack & slv_ce);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (slv_ce[i]) begin
                w_sel_rdata = w_sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 256) ? 8 : 16;

    logic [CNT_W-1:0] r_tmo_cnt;

    // Fires on the ACCESS cycle whose increment would make the count reach TIMEOUT.
    assign w_timeout = (r_state == S_ACCESS) && ((int'(r_tmo_cnt) + 1) >= TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_ACCESS) begin
            r_tmo_cnt <= '0;
        end else if (!w_sel_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_ce) begin
                    w_state_nxt = w_mapped ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (w_sel_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; an ack always takes priority over a timeout.
    always_comb begin
        w_slv_ce_nxt    = slv_ce;
        w_slv_we_nxt    = slv_we;
        w_slv_addr_nxt  = slv_addr;
        w_slv_wdata_nxt = slv_wdata;
        w_rdata_nxt     = cpu_rdata;
        w_ready_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_ce) begin
                    w_slv_we_nxt    = cpu_we;
                    w_slv_addr_nxt  = cpu_addr;
                    w_slv_wdata_nxt = cpu_wdata;
                    w_slv_ce_nxt    = w_dec_ce;
                    if (!w_mapped) begin
                        w_ready_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (w_sel_ack) begin
                    w_slv_ce_nxt = '0;
                    w_ready_nxt  = 1'b1;
                    w_rdata_nxt  = slv_we ? '0 : w_sel_rdata;
                end else if (w_timeout) begin
                    w_slv_ce_nxt = '0;
                    w_ready_nxt  = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_rdata_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slv_ce    <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            slv_ce    <= w_slv_ce_nxt;
            slv_we    <= w_slv_we_nxt;
            slv_addr  <= w_slv_addr_nxt;
            slv_wdata <= w_slv_wdata_nxt;
            cpu_rdata <= w_rdata_nxt;
            cpu_ready <= w_ready_nxt;
            cpu_err   <= w_err_nxt;
        end
    end

endmodule

// File: doc/dbus_interconnect.md
Name: dbus_interconnect

Overview:
- Parametrised data-bus interconnect between the CPU data port (ram_*) and N_SLAVES memory-mapped targets: data RAM, peripherals, and future devices.
- Adds what the flat single-RAM hookup lacks: address-region decode, per-slave ack/wait-state handshake, a registered response with stall to the CPU, and bus-error reporting for unmapped addresses and hung slaves.
- Instantiated in the SoC top between cpu and the data-side slaves.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- N_SLAVES, 4, number of slave ports (1..16)
- SEL_LSB, 28, lowest address bit of the region index; region index = addr[SEL_LSB+3:SEL_LSB]
- TIMEOUT, 255, wait cycles in ACCESS before a timeout error (only with DBUS_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_ce  in  1  CPU access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data; valid only while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  bus error, qualified by cpu_ready
- slv_ce  out  N_SLAVES  one-hot slave select
- slv_we  out  1  shared write strobe
- slv_addr  out  ADDR_W  shared latched address
- slv_wdata  out  DATA_W  shared latched write data
- slv_rdata  in  N_SLAVES*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W]
- slv_ack  in  N_SLAVES  slave i completes the access in the current cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; timeout counter 0. Reset asserted mid-access drops slv_ce immediately, and the in-flight access is discarded.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - cpu_ce is sampled only here.
  - On cpu_ce=1, latch addr/we/wdata into slv_addr/slv_we/slv_wdata and decode idx = cpu_addr[SEL_LSB+3:SEL_LSB].
  - idx < N_SLAVES: go to ACCESS, and slv_ce[idx] rises on the same edge.
  - idx >= N_SLAVES (unmapped): go directly to RESP with err=1, rdata=0; no slv_ce is asserted.
- ACCESS:
  - slv_ce[idx] is held high and all slave-side outputs are stable.
  - When slv_ack[idx]=1 at a clock edge: capture the selected slv_rdata slice (reads; writes capture 0), drop slv_ce, go to RESP with err=0.
  - Acks from non-selected slaves are ignored.
- RESP:
  - cpu_ready=1 for exactly one cycle, with cpu_rdata and cpu_err registered.
  - Next state is always IDLE; no back-to-back acceptance from RESP.
- Latency: with request in cycle T and a zero-wait slave (ack in its first ACCESS cycle), cpu_ready is high in T+2. Each slave wait cycle adds 1. An unmapped access gives cpu_ready in T+1.
- The CPU holds cpu_ce/addr/we/wdata until it sees cpu_ready. If cpu_ce is still high in the IDLE cycle after RESP, that is a new access.
- Outside RESP: cpu_ready=0, cpu_err=0, and cpu_rdata holds its last value.
- All outputs are registered; there is no combinational path from slave inputs to CPU outputs.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT: drop slv_ce and go to RESP with err=1, rdata=0.
  - An ack arriving in the same cycle the timeout triggers wins (normal completion).
- When undefined: no counter; ACCESS waits indefinitely for ack.

Test Plan:
- Read, zero-wait: slave 0 acks immediately with 0x1234_5678, cpu_addr=0x0000_0010, cpu_we=0 → slv_ce=4'b0001 in T+1; cpu_ready=1, cpu_rdata=0x1234_5678, cpu_err=0 in T+2.
- Write with 3 wait states: cpu_addr=0x2000_0004, cpu_wdata=0xCAFE_F00D, cpu_we=1; slave 2 acks on its 4th ACCESS cycle → slv_ce=4'b0100 with slv_wdata=0xCAFE_F00D held for 4 cycles; cpu_ready in T+5, err=0.
- Unmapped region: N_SLAVES=4, cpu_addr=0x5000_0000 → slv_ce stays 0; cpu_ready=1, cpu_err=1, cpu_rdata=0 in T+1.
- Timeout (DBUS_TIMEOUT_EN, TIMEOUT=8): slave 1 never acks → slv_ce[1] high for 8 cycles then drops; cpu_ready=1, cpu_err=1 in the following cycle.
- Stray ack plus back-to-back: slave 3 acks while slave 0 is selected, so the stray ack is ignored; cpu_ce held high after the first completion → second access starts from IDLE one cycle after RESP.
- Reset mid-access: rst driven to 0 during ACCESS → slv_ce=0 and cpu_ready=0 immediately, before the next edge; after release, state is IDLE and the next request completes normally.
